// File: rtl/surf_cmd_tx_if.sv
// CMD transmitter request/status bundle: {op, buf} request handshake plus line and status outputs.
// Latency: none, this is wiring only.
// Backpressure: cmd_ready_o low holds off the requester; a push needs valid and ready on the same edge.
interface surf_cmd_tx_if #(
  parameter int FIFO_AW = 2
);
  logic               cmd_valid_i;
  logic [2:0]         cmd_op_i;
  logic [1:0]         cmd_buf_i;
  logic               cmd_ready_o;
  logic               cmd_o;
  logic               busy_o;
  logic [FIFO_AW:0]   fifo_level_o;
  logic [15:0]        sent_count_o;

  // Requester side (TURF logic or self-test source)
  modport master (
    output cmd_valid_i, cmd_op_i, cmd_buf_i,
    input  cmd_ready_o, cmd_o, busy_o, fifo_level_o, sent_count_o
  );

  // Transmitter side
  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_buf_i,
    output cmd_ready_o, cmd_o, busy_o, fifo_level_o, sent_count_o
  );
endinterface

// File: rtl/surf_cmd_tx.sv
// Serial CMD-line encoder: queues {op, buf} in a small FIFO and shifts out framed commands MSB first.
// Latency: push on edge k -> pop on k+1 -> start bit on the line from k+2; frame period FRAME_W+GAP_CYCLES+1.
// Backpressure: cmd_ready_o drops while the FIFO is full (from the registered level); optional parity bit: CMD_TX_PARITY_EN.
module surf_cmd_tx #(
  parameter int GAP_CYCLES = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic           clk_i,
  input  logic           nrst_i,
  surf_cmd_tx_if.slave   bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

`ifdef CMD_TX_PARITY_EN
  localparam int FRAME_W = 8;
`else
  localparam int FRAME_W = 7;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t               state, state_nx;
  logic [4:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     level;
  logic                 push, pop;
  logic [4:0]           head;
  logic [FRAME_W-1:0]   frame_ld, sr;
  logic [3:0]           bit_cnt, gap_cnt;
  logic                 cmd_q, busy_q;
  logic [15:0]          sent_cnt;
  logic                 shift_done, gap_done, fifo_nonempty;

  assign bus.cmd_ready_o  = (level != DEPTH_L);
  assign push             = bus.cmd_valid_i & bus.cmd_ready_o;
  assign fifo_nonempty    = (level != '0);
  assign head             = mem[rd_ptr];
  assign shift_done       = (bit_cnt == 4'(FRAME_W));
  assign gap_done         = (gap_cnt == 4'(GAP_CYCLES - 1));

  // Frame image loaded at pop: start, op[2:0], buf[1:0], [odd parity], stop
`ifdef CMD_TX_PARITY_EN
  assign frame_ld = {1'b1, head, ~^head, 1'b0};
`else
  assign frame_ld = {1'b1, head, 1'b0};
`endif

  // FIFO storage; contents need no reset because level/pointers gate every read
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {bus.cmd_op_i, bus.cmd_buf_i};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Next-state: the last gap cycle pops directly so back-to-back frames need only one extra cycle
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop      = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_done) state_nx = GAP;
      end
      GAP: begin
        if (gap_done) begin
          if (fifo_nonempty) begin
            pop      = 1'b1;
            state_nx = SHIFT;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) state <= IDLE;
    else         state <= state_nx;
  end

  // Shifter, line register, counters; the line is driven from the register so it is glitch-free
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sr       <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      cmd_q    <= 1'b0;
      busy_q   <= 1'b0;
      sent_cnt <= '0;
    end else begin
      cmd_q   <= (state == SHIFT) ? sr[FRAME_W-1] : 1'b0;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      busy_q  <= (state != IDLE) || fifo_nonempty;
      if (pop) begin
        sr      <= frame_ld;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        sr      <= {sr[FRAME_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
      end
      // The edge that leaves SHIFT is the one that ends the stop bit
      if (state == SHIFT && shift_done) sent_cnt <= sent_cnt + 1'b1;
    end
  end

  assign bus.cmd_o        = cmd_q;
  assign bus.busy_o       = busy_q;
  assign bus.fifo_level_o = level;
  assign bus.sent_count_o = sent_cnt;

endmodule
